inst_loader: RTL
================

INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 SHALL have parameter IMEM_DEPTH, default 64, meaning the maximum number of 32-bit words accepted.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0, meaning the byte address of the first word written.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port byte_valid  input  1  meaning byte_data is offered.
REQ-006 SHALL have port byte_data  input  8  meaning the load-stream byte.
REQ-007 SHALL have port byte_ready  output  1  meaning the loader accepts a byte this cycle.
REQ-008 SHALL have port imem_we  output  1  meaning the IMEM write strobe.
REQ-009 SHALL have port imem_waddr  output  32  meaning the IMEM byte address.
REQ-010 SHALL have port imem_wdata  output  32  meaning the IMEM write word.
REQ-011 SHALL have port core_rst  output  1  meaning the reset driven to the core PC/RegisterFile.
REQ-012 SHALL have port done  output  1  meaning the load completed successfully.
REQ-013 SHALL have port error  output  1  meaning the load was aborted.

Function
REQ-014 SHALL accept a byte only on a cycle where byte_valid and byte_ready are both high; nothing else consumes a byte.
REQ-015 SHALL use the stream format: 16-bit word count N (low byte first), then 4*N data bytes, each word little-endian (first byte goes to bits 7:0).
REQ-016 SHALL implement states CNT_LO, CNT_HI, DATA, CHK, DONE, ERROR; CNT_LO→CNT_HI→DATA on accepted bytes.
REQ-017 SHALL go from CNT_HI to DONE when N=0, and to ERROR when N>IMEM_DEPTH, in the cycle after the high byte is accepted.
REQ-018 SHALL pulse imem_we high for exactly one cycle, in the cycle after the 4th byte of a word is accepted, with imem_waddr = BASE_ADDR + 4*word_index.
REQ-019 SHALL hold imem_waddr and imem_wdata stable while imem_we is high, and SHALL increment word_index after each write (wrapping to 0 on restart only).
REQ-020 SHALL leave DATA after the 4th byte of word N-1, going to CHK (macro defined) or DONE (macro undefined).
REQ-021 SHALL drive byte_ready high in CNT_LO, CNT_HI, DATA, and CHK, and low in DONE and ERROR.
REQ-022 SHALL drive core_rst high in every state except DONE; done is high only in DONE; error is high only in ERROR.
REQ-023 SHALL remain in DONE or ERROR until rst; byte_valid is ignored there.
REQ-024 SHALL allow back-to-back accepted bytes on consecutive cycles with no bubble.

Reset
REQ-025 SHALL on rst (any state, including mid-word) enter CNT_LO, clear word_index, the byte lane counter, the count, and the checksum.
REQ-026 SHALL drive these reset values: byte_ready=1 after the reset cycle, imem_we=0, imem_waddr=BASE_ADDR, imem_wdata=0, core_rst=1, done=0, error=0.
REQ-027 SHALL discard any partially assembled word when reset arrives mid-load, with no write issued.

Configuration
REQ-028 SHALL, with INST_LOADER_CHECKSUM_EN defined, XOR all data bytes into an 8-bit checksum and accept one trailing byte in CHK.
REQ-029 SHALL then go to DONE if the trailing byte equals the checksum and to ERROR otherwise, and with N=0 SHALL go CNT_HI→CHK, expecting 8'h00.
REQ-030 SHALL, without INST_LOADER_CHECKSUM_EN, omit the CHK state and checksum logic, so no trailing byte is consumed.

Verification
REQ-031 SHALL cover: stream 01 00 13 05 A0 00 (+ checksum B6 if macro) → one imem_we, addr 0x0, data 0x00A00513, then done=1 and core_rst=0.
REQ-032 SHALL cover: N=3 bytes streamed with byte_valid held high → writes at 0x0, 0x4, 0x8 on three single-cycle pulses; byte_ready never drops before DONE.
REQ-033 SHALL cover: count 0x0041 with IMEM_DEPTH=64 → error=1, byte_ready=0, core_rst=1, and no imem_we.
REQ-034 SHALL cover: rst asserted after 2 bytes of word 1 → no write for word 1, state CNT_LO; a fresh 1-word load then writes addr 0x0.
REQ-035 SHALL cover: macro defined, N=1, wrong checksum byte → word written, then error=1 and core_rst held 1.
REQ-036 SHALL cover: byte_valid toggling 1/0 randomly during a 2-word load → the data assembled matches the accepted bytes only.

Source files
------------

// File: rtl/inst_loader.sv
// inst_loader: byte-stream loader that writes 32-bit words into IMEM while holding the core in reset.
//   Optional checksum trailer enabled by defining INST_LOADER_CHECKSUM_EN.
//   Ports:
//     clk, rst         - clock, synchronous active-high reset
//     byte_valid/data  - incoming load-stream byte
//     byte_ready       - loader accepts a byte this cycle
//     imem_we/waddr/wdata - single-cycle IMEM write (byte address, word)
//     core_rst         - held high until the load completes
//     done, error      - load finished successfully / aborted
module inst_loader #(
    parameter int          IMEM_DEPTH = 64,
    parameter logic [31:0] BASE_ADDR  = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        imem_we,
    output logic [31:0] imem_waddr,
    output logic [31:0] imem_wdata,
    output logic        core_rst,
    output logic        done,
    output logic        error
);
`ifdef INST_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {CNT_LO, CNT_HI, DATA, CHK, DONE, ERROR} state_t;
`else
    typedef enum logic [2:0] {CNT_LO, CNT_HI, DATA, DONE, ERROR} state_t;
`endif
    localparam logic [16:0] DEPTH = 17'(IMEM_DEPTH);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] idx_q, idx_d;
    logic [1:0]  lane_q, lane_d;
    logic [23:0] asm_q, asm_d;
    logic        we_q, we_d;
    logic [31:0] waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;
`ifdef INST_LOADER_CHECKSUM_EN
    logic [7:0]  sum_q, sum_d;
`endif
    logic        acc;
    logic [15:0] cnt_new;

    assign acc     = byte_valid && byte_ready;
    assign cnt_new = {byte_data, cnt_q[7:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        lane_d  = lane_q;
        asm_d   = asm_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
`ifdef INST_LOADER_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        if (acc) begin
            case (state_q)
                CNT_LO: begin
                    cnt_d[7:0] = byte_data;
                    state_d    = CNT_HI;
                end
                CNT_HI: begin
                    cnt_d = cnt_new;
`ifdef INST_LOADER_CHECKSUM_EN
                    state_d = (cnt_new == 16'd0) ? CHK :
                              ({1'b0, cnt_new} > DEPTH) ? ERROR : DATA;
`else
                    state_d = (cnt_new == 16'd0) ? DONE :
                              ({1'b0, cnt_new} > DEPTH) ? ERROR : DATA;
`endif
                end
                DATA: begin
                    // Bytes shift in from the top so the first byte ends in bits 7:0.
                    lane_d = lane_q + 2'd1;
                    asm_d  = {byte_data, asm_q[23:8]};
`ifdef INST_LOADER_CHECKSUM_EN
                    sum_d  = sum_q ^ byte_data;
`endif
                    if (lane_q == 2'd3) begin
                        we_d    = 1'b1;
                        waddr_d = BASE_ADDR + 32'({idx_q, 2'b00});
                        wdata_d = {byte_data, asm_q};
                        idx_d   = idx_q + 16'd1;
                        if (idx_q == cnt_q - 16'd1) begin
`ifdef INST_LOADER_CHECKSUM_EN
                            state_d = CHK;
`else
                            state_d = DONE;
`endif
                        end
                    end
                end
`ifdef INST_LOADER_CHECKSUM_EN
                CHK: state_d = (byte_data == sum_q) ? DONE : ERROR;
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CNT_LO;
            cnt_q   <= '0;
            idx_q   <= '0;
            lane_q  <= '0;
            asm_q   <= '0;
            we_q    <= 1'b0;
            waddr_q <= BASE_ADDR;
            wdata_q <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            lane_q  <= lane_d;
            asm_q   <= asm_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
`ifdef INST_LOADER_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    assign byte_ready = (state_q != DONE) && (state_q != ERROR);
    assign imem_we    = we_q;
    assign imem_waddr = waddr_q;
    assign imem_wdata = wdata_q;
    assign core_rst   = (state_q != DONE);
    assign done       = (state_q == DONE);
    assign error      = (state_q == ERROR);
endmodule
